// File: rtl/control_fsm_if.sv
// Handshake and strobe bundle between the CoreTech main control FSM and its datapath.
// The slave modport is the controller side; master is the datapath/memory side.
interface control_fsm_if;
    logic        i_Start;
    logic [15:0] i_Instr;
    logic        i_MemReady;
    logic        i_Zero;

    logic        o_MemRead;
    logic        o_MemWrite;
    logic        o_IorD;
    logic        o_IRWrite;
    logic        o_PCInc;
    logic        o_PCLoad;
    logic [1:0]  o_ALUOp;
    logic        o_ALUSrc;
    logic        o_RegWrite;
    logic        o_MemToReg;
    logic        o_Illegal;
    logic        o_Halted;
    logic [15:0] o_InstrCount;

    modport master (
        output i_Start, i_Instr, i_MemReady, i_Zero,
        input  o_MemRead, o_MemWrite, o_IorD, o_IRWrite, o_PCInc, o_PCLoad,
               o_ALUOp, o_ALUSrc, o_RegWrite, o_MemToReg, o_Illegal, o_Halted,
               o_InstrCount
    );

    modport slave (
        input  i_Start, i_Instr, i_MemReady, i_Zero,
        output o_MemRead, o_MemWrite, o_IorD, o_IRWrite, o_PCInc, o_PCLoad,
               o_ALUOp, o_ALUSrc, o_RegWrite, o_MemToReg, o_Illegal, o_Halted,
               o_InstrCount
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle main control FSM: fetch/decode/exec/mem/writeback sequencing with a
// ready handshake on memory, plus a 16-bit retired-instruction counter.
module control_fsm (
    input  logic        i_clk,
    input  logic        i_rst,
    control_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q;
    logic        retire;

    logic [3:0]  opcode;
    logic        is_alu, is_load, is_store, is_beq, is_halt, is_illegal;
    logic        unused_instr;

    assign opcode       = bus.i_Instr[15:12];
    assign unused_instr = ^bus.i_Instr[11:0];
    assign is_alu       = (opcode[3:2] == 2'b00);
    assign is_load      = (opcode == 4'b0100);
    assign is_store     = (opcode == 4'b0101);
    assign is_beq       = (opcode == 4'b0110);
    assign is_halt      = (opcode == 4'b1111);
    assign is_illegal   = !(is_alu || is_load || is_store || is_beq || is_halt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                count_q <= count_q + 16'd1;
        end
    end

    assign bus.o_InstrCount = count_q;

    always_comb begin
        state_d        = state_q;
        retire         = 1'b0;
        bus.o_MemRead  = 1'b0;
        bus.o_MemWrite = 1'b0;
        bus.o_IorD     = 1'b0;
        bus.o_IRWrite  = 1'b0;
        bus.o_PCInc    = 1'b0;
        bus.o_PCLoad   = 1'b0;
        bus.o_ALUOp    = 2'b00;
        bus.o_ALUSrc   = 1'b0;
        bus.o_RegWrite = 1'b0;
        bus.o_MemToReg = 1'b0;
        bus.o_Illegal  = 1'b0;
        bus.o_Halted   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_Start)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.o_MemRead = 1'b1;
                if (bus.i_MemReady) begin
                    bus.o_IRWrite = 1'b1;
                    bus.o_PCInc   = 1'b1;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt)
                    state_d = S_HALT;
                else if (is_illegal) begin
                    bus.o_Illegal = 1'b1;
                    state_d       = S_FETCH;
                end else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                // ADD/SUB/AND/OR opcodes carry their ALU class in the low two bits.
                if (is_alu) begin
                    bus.o_ALUOp = opcode[1:0];
                    state_d     = S_WB;
                end else if (is_load || is_store) begin
                    bus.o_ALUSrc = 1'b1;
                    state_d      = S_MEM;
                end else begin
                    bus.o_ALUOp  = 2'b01;
                    bus.o_PCLoad = bus.i_Zero;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_MEM: begin
                bus.o_IorD     = 1'b1;
                bus.o_ALUSrc   = 1'b1;
                bus.o_MemRead  = is_load;
                bus.o_MemWrite = is_store;
                if (bus.i_MemReady) begin
                    if (is_load)
                        state_d = S_WB;
                    else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                bus.o_RegWrite = 1'b1;
                bus.o_MemToReg = is_load;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                bus.o_Halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// Directed-vector bench for control_fsm: each row drives one cycle of inputs and
// checks the packed strobe vector and the retired-instruction count.
module tb_control_fsm;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    control_fsm_if bus ();

    control_fsm dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {MemRead, MemWrite, IorD, IRWrite, PCInc, PCLoad, ALUOp[1:0], ALUSrc, RegWrite, MemToReg, Illegal, Halted}
    logic [12:0] outs;
    assign outs = {bus.o_MemRead, bus.o_MemWrite, bus.o_IorD, bus.o_IRWrite, bus.o_PCInc,
                   bus.o_PCLoad, bus.o_ALUOp, bus.o_ALUSrc, bus.o_RegWrite, bus.o_MemToReg,
                   bus.o_Illegal, bus.o_Halted};

    localparam logic [12:0] P_NONE    = 13'h0000;
    localparam logic [12:0] P_FSTALL  = 13'h1000;
    localparam logic [12:0] P_FREADY  = 13'h1300;
    localparam logic [12:0] P_ILL     = 13'h0002;
    localparam logic [12:0] P_SUB     = 13'h0020;
    localparam logic [12:0] P_AND     = 13'h0040;
    localparam logic [12:0] P_OR      = 13'h0060;
    localparam logic [12:0] P_EXMEM   = 13'h0010;
    localparam logic [12:0] P_BEQ_T   = 13'h00A0;
    localparam logic [12:0] P_MEMLD   = 13'h1410;
    localparam logic [12:0] P_MEMST   = 13'h0C10;
    localparam logic [12:0] P_WBALU   = 13'h0008;
    localparam logic [12:0] P_WBLD    = 13'h000C;
    localparam logic [12:0] P_HALT    = 13'h0001;

    typedef struct {
        logic        start;
        logic        ready;
        logic        zero;
        logic [15:0] instr;
        logic [12:0] exp;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(logic s, logic r, logic z, logic [15:0] ins,
                                logic [12:0] e, logic [15:0] c);
        vec_t v;
        v.start = s; v.ready = r; v.zero = z; v.instr = ins; v.exp = e; v.cnt = c;
        return v;
    endfunction

    task automatic drive(vec_t v);
        bus.i_Start    = v.start;
        bus.i_MemReady = v.ready;
        bus.i_Zero     = v.zero;
        bus.i_Instr    = v.instr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_Start = 1'b0; bus.i_MemReady = 1'b0; bus.i_Zero = 1'b0; bus.i_Instr = 16'h0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_MemReady = 1'b1;
            #1;
            checks++;
            if (outs !== P_NONE) begin
                errors++; $display("FAIL reset[%0d] outs=%h expected %h", i, outs, P_NONE);
            end
            checks++;
            if (bus.o_InstrCount !== 16'h0) begin
                errors++; $display("FAIL reset_cnt[%0d] cnt=%h expected 0000", i, bus.o_InstrCount);
            end
            next_cycle();
        end
    endtask

    task automatic test_add();
        vec_t v[$];
        v.push_back(mk(1, 0, 0, 16'h0123, P_NONE,   16'd0));
        v.push_back(mk(0, 1, 0, 16'h0123, P_FREADY, 16'd0));
        v.push_back(mk(0, 1, 0, 16'h0123, P_NONE,   16'd0));
        v.push_back(mk(0, 1, 1, 16'h0123, P_NONE,   16'd0));
        v.push_back(mk(0, 1, 0, 16'h0123, P_WBALU,  16'd0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL add[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL add_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_alu_ops();
        vec_t v[$];
        logic [15:0] ins [3] = '{16'h1abc, 16'h2abc, 16'h3abc};
        logic [12:0] ex  [3] = '{P_SUB, P_AND, P_OR};
        for (int k = 0; k < 3; k++) begin
            v.push_back(mk(0, 1, 0, ins[k], P_FREADY, 16'(k + 1)));
            v.push_back(mk(0, 1, 0, ins[k], P_NONE,   16'(k + 1)));
            v.push_back(mk(0, 1, 0, ins[k], ex[k],    16'(k + 1)));
            v.push_back(mk(0, 1, 0, ins[k], P_WBALU,  16'(k + 1)));
        end
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL alu[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL alu_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_stall();
        vec_t v[$];
        v.push_back(mk(0, 0, 0, 16'h4abc, P_FSTALL, 16'd4));
        v.push_back(mk(0, 1, 0, 16'h4abc, P_FREADY, 16'd4));
        v.push_back(mk(0, 1, 0, 16'h4abc, P_NONE,   16'd4));
        v.push_back(mk(0, 1, 0, 16'h4abc, P_EXMEM,  16'd4));
        v.push_back(mk(0, 0, 0, 16'h4abc, P_MEMLD,  16'd4));
        v.push_back(mk(0, 0, 0, 16'h4abc, P_MEMLD,  16'd4));
        v.push_back(mk(0, 0, 0, 16'h4abc, P_MEMLD,  16'd4));
        v.push_back(mk(0, 1, 0, 16'h4abc, P_MEMLD,  16'd4));
        v.push_back(mk(0, 1, 0, 16'h4abc, P_WBLD,   16'd4));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL load[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL load_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_store_beq();
        vec_t v[$];
        v.push_back(mk(0, 1, 0, 16'h5abc, P_FREADY, 16'd5));
        v.push_back(mk(0, 1, 0, 16'h5abc, P_NONE,   16'd5));
        v.push_back(mk(0, 1, 0, 16'h5abc, P_EXMEM,  16'd5));
        v.push_back(mk(0, 1, 0, 16'h5abc, P_MEMST,  16'd5));
        v.push_back(mk(0, 1, 1, 16'h6abc, P_FREADY, 16'd6));
        v.push_back(mk(0, 1, 1, 16'h6abc, P_NONE,   16'd6));
        v.push_back(mk(0, 1, 1, 16'h6abc, P_BEQ_T,  16'd6));
        v.push_back(mk(0, 1, 1, 16'h6abc, P_FREADY, 16'd7));
        v.push_back(mk(0, 1, 1, 16'h6abc, P_NONE,   16'd7));
        v.push_back(mk(0, 1, 0, 16'h6abc, P_SUB,    16'd7));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL store_beq[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL store_beq_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back(mk(0, 1, 0, 16'h7000, P_FREADY, 16'd8));
        v.push_back(mk(0, 1, 0, 16'h7000, P_ILL,    16'd8));
        v.push_back(mk(0, 1, 0, 16'h8000, P_FREADY, 16'd8));
        v.push_back(mk(0, 1, 0, 16'h8000, P_ILL,    16'd8));
        v.push_back(mk(0, 0, 0, 16'h8000, P_FSTALL, 16'd8));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL illegal[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL illegal_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        vec_t v[$];
        v.push_back(mk(0, 1, 0, 16'h5000, P_FREADY, 16'hFFFF));
        v.push_back(mk(0, 1, 0, 16'h5000, P_NONE,   16'hFFFF));
        v.push_back(mk(0, 1, 0, 16'h5000, P_EXMEM,  16'hFFFF));
        v.push_back(mk(0, 1, 0, 16'h5000, P_MEMST,  16'hFFFF));
        v.push_back(mk(0, 0, 0, 16'h5000, P_FSTALL, 16'h0000));
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL wrap[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL wrap_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_rst_stall();
        // Currently stalled in FETCH with count 0; bring count up first via one BEQ.
        vec_t v[$];
        v.push_back(mk(0, 1, 0, 16'h6000, P_FREADY, 16'd0));
        v.push_back(mk(0, 1, 0, 16'h6000, P_NONE,   16'd0));
        v.push_back(mk(0, 1, 0, 16'h6000, P_SUB,    16'd0));
        v.push_back(mk(0, 0, 0, 16'h6000, P_FSTALL, 16'd1));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL rst_stall[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL rst_stall_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            if (i == v.size() - 1) rst = 1'b1;
            next_cycle();
        end
        rst = 1'b0;
        bus.i_MemReady = 1'b1;
        #1;
        checks++;
        if (outs !== P_NONE) begin
            errors++; $display("FAIL rst_stall_after outs=%h expected %h", outs, P_NONE);
        end
        checks++;
        if (bus.o_InstrCount !== 16'd0) begin
            errors++; $display("FAIL rst_stall_after_cnt cnt=%h expected 0000", bus.o_InstrCount);
        end
        next_cycle();
    endtask

    task automatic test_halt();
        vec_t v[$];
        v.push_back(mk(1, 0, 0, 16'h6000, P_NONE,   16'd0));
        v.push_back(mk(0, 1, 0, 16'h6000, P_FREADY, 16'd0));
        v.push_back(mk(0, 1, 0, 16'h6000, P_NONE,   16'd0));
        v.push_back(mk(0, 1, 0, 16'h6000, P_SUB,    16'd0));
        v.push_back(mk(0, 1, 0, 16'hF000, P_FREADY, 16'd1));
        v.push_back(mk(0, 1, 0, 16'hF000, P_NONE,   16'd1));
        for (int k = 0; k < 22; k++)
            v.push_back(mk(k[0], k[1], 1, 16'hF000, P_HALT, 16'd1));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                errors++; $display("FAIL halt[%0d] outs=%h expected %h", i, outs, v[i].exp);
            end
            checks++;
            if (bus.o_InstrCount !== v[i].cnt) begin
                errors++; $display("FAIL halt_cnt[%0d] cnt=%h expected %h", i, bus.o_InstrCount, v[i].cnt);
            end
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.i_Start = 1'b0;
        #1;
        checks++;
        if (outs !== P_NONE) begin
            errors++; $display("FAIL halt_rst outs=%h expected %h", outs, P_NONE);
        end
        checks++;
        if (bus.o_InstrCount !== 16'd0) begin
            errors++; $display("FAIL halt_rst_cnt cnt=%h expected 0000", bus.o_InstrCount);
        end
        next_cycle();
        #1;
        checks++;
        if (outs !== P_NONE) begin
            errors++; $display("FAIL halt_idle outs=%h expected %h", outs, P_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_load_stall();
        test_store_beq();
        test_illegal();
        test_wrap();
        test_rst_stall();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle main control unit for the CoreTech processor, directly upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives the datapath strobes. It also drives the 2-bit `o_ALUOp` that the ALU control decoder expands into the 4-bit ALU operation. Memory accesses use a ready handshake, so the FSM stalls for variable-latency memory.

## Interface
- No parameters. Instruction width is 16 bits, opcode field is `[15:12]`, and the retired-instruction counter is 16 bits.
- `i_clk` input 1: single clock; all state updates on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_Start` input 1: leave IDLE and begin fetching.
- `i_Instr` input 16: instruction register contents; decoded in DECODE and later states.
- `i_MemReady` input 1: memory has completed the current read or write this cycle.
- `i_Zero` input 1: ALU zero flag, sampled in EXEC for BEQ.
- `o_MemRead` output 1: memory read request.
- `o_MemWrite` output 1: memory write request.
- `o_IorD` output 1: address select; 0 selects PC, 1 selects the ALU result.
- `o_IRWrite` output 1: load the instruction register.
- `o_PCInc` output 1: PC <= PC+1.
- `o_PCLoad` output 1: PC <= branch target.
- `o_ALUOp` output 2: operation class sent to the ALU control decoder.
- `o_ALUSrc` output 1: 0 selects register B, 1 selects the sign-extended immediate.
- `o_RegWrite` output 1: register file write enable.
- `o_MemToReg` output 1: writeback source; 1 selects memory data.
- `o_Illegal` output 1: one-cycle pulse on an undefined opcode.
- `o_Halted` output 1: high while in the HALT state.
- `o_InstrCount` output 16: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. A binary or one-hot encoding is free, but no other states are allowed.
- Outputs are decoded from the current state. Outputs marked "Mealy" are additionally qualified by the listed inputs in the same cycle.
- Any output not asserted in a state is 0. `o_ALUOp` defaults to 00.
- Opcode decode:
  - 0000 ADD: ALUOp 00.
  - 0001 SUB: ALUOp 01.
  - 0010 AND: ALUOp 10.
  - 0011 OR: ALUOp 11.
  - 0100 LOAD: ALUOp 00, ALUSrc 1.
  - 0101 STORE: ALUOp 00, ALUSrc 1.
  - 0110 BEQ: ALUOp 01.
  - 1111 HALT.
  - All other opcodes are illegal.
- IDLE: all outputs 0. Move to FETCH when `i_Start`=1.
- FETCH: `o_MemRead`=1 and `o_IorD`=0.
  - While `i_MemReady`=0, stay in FETCH.
  - When `i_MemReady`=1 (Mealy): `o_IRWrite`=1 and `o_PCInc`=1, then move to DECODE.
- DECODE: one cycle.
  - HALT opcode: move to HALT.
  - Illegal opcode (Mealy): `o_Illegal`=1, then move to FETCH. `o_InstrCount` does not increment.
  - Otherwise: move to EXEC.
- EXEC: `o_ALUOp` and `o_ALUSrc` are driven per the opcode table.
  - ALU ops (ADD, SUB, AND, OR): move to WB.
  - LOAD or STORE: move to MEM.
  - BEQ: `o_PCLoad` = `i_Zero` (Mealy); retire the instruction; move to FETCH.
- MEM: `o_IorD`=1, `o_ALUOp`=00, `o_ALUSrc`=1. `o_MemRead`=1 for LOAD, `o_MemWrite`=1 for STORE.
  - While `i_MemReady`=0, stay in MEM with the request held.
  - When `i_MemReady`=1: LOAD moves to WB; STORE retires and moves to FETCH.
- WB: `o_RegWrite`=1 for exactly one cycle. `o_MemToReg`=1 for LOAD, 0 otherwise. Retire; move to FETCH.
- HALT: `o_Halted`=1. Remain in HALT until `i_rst`; `i_Start` is ignored.
- `o_InstrCount` increments by 1 on each retire: leaving WB, leaving EXEC for BEQ, and leaving MEM for STORE.
  - It wraps from 0xFFFF to 0x0000.
  - The HALT instruction is not counted.
- `i_Instr` only needs to be valid from DECODE onward. The FSM never samples it in IDLE or FETCH.

## Timing
- Reset: on a rising edge with `i_rst`=1, state <= IDLE and `o_InstrCount` <= 0. All other outputs read 0 in the following cycle.
- `i_rst` overrides every other input, including mid-stall in FETCH or MEM and in HALT. Outstanding requests are dropped the cycle after reset.
- Minimum cycles per instruction, with `i_MemReady` high on the first request cycle:
  - ALU ops: 4 (FETCH, DECODE, EXEC, WB).
  - LOAD: 5.
  - STORE: 4.
  - BEQ: 3.
  - Each cycle of `i_MemReady`=0 adds one stall cycle in FETCH or MEM.
- Handshake rules:
  - A request, once asserted, remains steady until the cycle in which `i_MemReady`=1.
  - `i_MemReady` is ignored outside FETCH and MEM.
- Pulse widths:
  - `o_IRWrite`, `o_PCInc`, `o_PCLoad` and `o_RegWrite` are each exactly one cycle per instruction.
  - `o_Illegal` is exactly one cycle per illegal instruction.
- IDLE to the first FETCH request takes 1 cycle after `i_Start` is sampled high.

## Test plan
- Reset then `i_Start`; ADD (0x0123) with `i_MemReady` always 1 → FETCH/DECODE/EXEC/WB in 4 cycles; `o_ALUOp`=00 in EXEC; one `o_RegWrite` pulse; `o_InstrCount`=1.
- LOAD (0x4xxx) with `i_MemReady` low for 3 cycles in MEM → `o_MemRead` and `o_IorD` held for 4 cycles; WB has `o_MemToReg`=1; 8 cycles total.
- BEQ (0x6xxx) twice, once with `i_Zero`=1 and once with `i_Zero`=0 → first `o_PCLoad` pulses once in EXEC, second never pulses; `o_ALUOp`=01; 3 cycles each.
- Opcodes 0111 and 1000 → `o_Illegal` one-cycle pulse in DECODE; return to FETCH; count unchanged; no `o_RegWrite` or `o_MemWrite`.
- HALT (0xF000) → `o_Halted`=1 held for 20+ cycles with `i_Start` toggling; assert `i_rst` → IDLE with all outputs 0 and count 0.
- Preload the count to 0xFFFF via 65535 STOREs, or a forced counter value, then one more retire → count 0x0000. Assert `i_rst` during a FETCH stall → `o_MemRead` low the next cycle.
